mm8_ctrl: RTL and testbench
===========================

Name: mm8_ctrl

Overview:
- Job sequencer that drives the eight_x_eight systolic array load/compute interface. It is the initiator side of the array's write/row_ptr/enable protocol.
- Accepts A/B operand columns on a valid/ready stream, writes them into the array, and runs the compute window.
- Captures the array's c_out rows into a local result buffer, then streams them out on a second valid/ready port.
- Sits between the operand DMA/fetch logic and the array.

Parameters:
- DATA_WIDTH, 8, operand element width (signed)
- ACC_WIDTH, 32, accumulator/result element width (signed)
- N, 8, array dimension; fixes row_ptr width at $clog2(N)
- COMPUTE_LAT, 17, cycles from enable rising at the array to result row 0 valid on c_out; row r is valid at COMPUTE_LAT+r

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand column beat valid
- in_ready  out  1  operand column beat accepted when in_valid&in_ready
- in_a  in  N x DATA_WIDTH  column k of A (element j = A[j][k])
- in_b  in  N x DATA_WIDTH  column k of B (element j = B[j][k])
- arr_rst  out  1  array reset: rst OR controller clear pulse
- arr_write  out  1  array write strobe
- arr_row_ptr  out  $clog2(N)  array write row pointer
- arr_a_in  out  N x DATA_WIDTH  array A data
- arr_b_in  out  N x DATA_WIDTH  array B data
- arr_enable  out  1  array compute enable
- arr_c_out  in  N x ACC_WIDTH  array result row
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts result row
- out_c  out  N x ACC_WIDTH  result row
- out_row  out  $clog2(N)  index of the row on out_c
- out_last  out  1  high with row N-1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: in_ready=0, arr_write=0, arr_row_ptr=0, arr_a_in/arr_b_in=0, arr_enable=0, out_valid=0, out_row=0, out_last=0, busy=0.
- arr_rst=1 throughout rst.
- State machine: IDLE -> CLEAR -> LOAD -> COMPUTE -> DRAIN -> IDLE.
- IDLE: in_ready=0. Moves to CLEAR when in_valid=1; the beat is not consumed.
- CLEAR: one cycle with arr_rst=1, in_ready=0. Then moves to LOAD.
- LOAD:
  - in_ready=1.
  - Each handshake registers in_a/in_b into arr_a_in/arr_b_in, sets arr_write=1 and arr_row_ptr=beat count. The array sees the write one cycle after the handshake.
  - No handshake: arr_write=0 next cycle (bubbles allowed).
  - After beat N-1 is accepted: in_ready drops the next cycle; the cycle after the final write, go to COMPUTE.
- COMPUTE:
  - arr_enable=1, held continuously; cycle counter starts at 0.
  - When counter = COMPUTE_LAT+r (r = 0..N-1), arr_c_out is captured into result buffer slot r.
  - After slot N-1 is captured, arr_enable=0 and the state moves to DRAIN.
  - Capture is unconditional; the array output is never stalled.
- DRAIN:
  - Presents buffer slots 0..N-1 in order: out_valid=1, out_c=buf[out_row], out_last=(out_row==N-1).
  - Advances on out_valid&out_ready.
  - out_valid holds, and out_c is stable, while out_ready=0.
  - After the last handshake, returns to IDLE.
- Results are passed through unmodified: ACC_WIDTH wrap is the array's responsibility.
- arr_row_ptr wraps naturally, but never exceeds N-1 within a job.
- Back-to-back jobs: a job accepted directly after DRAIN must start in CLEAR, so no stale accumulators survive.
- rst mid-job (any state): next cycle all outputs are at reset values, the buffer is logically empty (no out_valid), and the partial job is dropped.

Optional Feature:
- MM_CTRL_PERF_EN
- Defined: adds output perf_cycles (32 bits, reset 0). The internal counter starts on the first LOAD handshake and stops on the out_last handshake. perf_cycles is updated at job end and holds until the next job ends.
- Undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Package mm8_pkg: state enum (IDLE, CLEAR, LOAD, COMPUTE, DRAIN), row-pointer typedef from N, and element typedefs for DATA_WIDTH/ACC_WIDTH vectors.
- Sub-module mm8_result_buf: N x (N x ACC_WIDTH) register file with write port (capture) and read port (drain index).
- FSM and counters stay in mm8_ctrl.

Test Plan:
- Reset: after rst, arr_rst=1, in_ready=0, out_valid=0, busy=0. One cycle after rst deasserts, arr_rst=0.
- Full job, no stalls, with A=identity and B[i][j]=i*8+j streamed contiguously:
  - arr_rst pulses for exactly one cycle.
  - arr_write is high 8 consecutive cycles with arr_row_ptr 0..7.
  - arr_enable is high COMPUTE_LAT+8 cycles.
  - Outputs are 8 rows matching a golden model of the array's outputs.
  - out_last is high only on row 7.
- Input bubbles: in_valid toggles 1,0,1,0 -> arr_write follows with gaps; arr_row_ptr stays sequential 0..7; results are identical to the no-bubble run.
- Output backpressure: out_ready=0 for 10 cycles mid-drain at row 3 -> out_valid stays high, out_row=3 and out_c are stable; all 8 rows still arrive exactly once.
- rst asserted during COMPUTE counter=5 -> next cycle arr_enable=0, busy=0. A following fresh job completes with correct results.
- With MM_CTRL_PERF_EN and the no-stall job -> perf_cycles = 8 + 1 + COMPUTE_LAT + 8 + 8 (exact per the FSM), and it is unchanged until the next job ends.

Source files
------------

// File: rtl/mm8_pkg.sv
// Shared types and default dimensions for the 8x8 matrix-multiply job sequencer.
package mm8_pkg;

    localparam int MM_N           = 8;
    localparam int MM_DATA_W      = 8;
    localparam int MM_ACC_W       = 32;
    localparam int MM_COMPUTE_LAT = 17;
    localparam int MM_PTR_W       = $clog2(MM_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    typedef logic [MM_PTR_W-1:0]        row_ptr_t;
    typedef logic signed [MM_DATA_W-1:0] data_t;
    typedef logic signed [MM_ACC_W-1:0]  acc_t;
    typedef data_t [MM_N-1:0]            data_vec_t;
    typedef acc_t  [MM_N-1:0]            acc_vec_t;

endpackage

// File: rtl/mm8_result_buf.sv
// Result row buffer: captures array c_out rows during compute, read by drain index.
module mm8_result_buf
    import mm8_pkg::*;
#(
    parameter int N         = MM_N,
    parameter int ACC_WIDTH = MM_ACC_W
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [$clog2(N)-1:0]   waddr_i,
    input  logic [N*ACC_WIDTH-1:0] wdata_i,
    input  logic [$clog2(N)-1:0]   raddr_i,
    output logic [N*ACC_WIDTH-1:0] rdata_o
);

    logic [N*ACC_WIDTH-1:0] mem_q [N];

    // NOTE: storage is not reset; out_valid in the controller decides when a slot is meaningful.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mm8_ctrl.sv
// Job sequencer for the 8x8 systolic array: load columns, run compute, drain result rows.
// Optional cycle counter output perf_cycles when MM_CTRL_PERF_EN is defined.
module mm8_ctrl
    import mm8_pkg::*;
#(
    parameter int DATA_WIDTH  = MM_DATA_W,
    parameter int ACC_WIDTH   = MM_ACC_W,
    parameter int N           = MM_N,
    parameter int COMPUTE_LAT = MM_COMPUTE_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a,
    input  logic [N*DATA_WIDTH-1:0] in_b,
    output logic                    arr_rst,
    output logic                    arr_write,
    output logic [$clog2(N)-1:0]    arr_row_ptr,
    output logic [N*DATA_WIDTH-1:0] arr_a_in,
    output logic [N*DATA_WIDTH-1:0] arr_b_in,
    output logic                    arr_enable,
    input  logic [N*ACC_WIDTH-1:0]  arr_c_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*ACC_WIDTH-1:0]  out_c,
    output logic [$clog2(N)-1:0]    out_row,
    output logic                    out_last,
    output logic                    busy
`ifdef MM_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_cycles
`endif
);

    localparam int PTR_W = $clog2(N);
    localparam int CNT_W = $clog2(COMPUTE_LAT + N);

    state_t                  state_q;
    logic                    clear_q;
    logic                    in_ready_q;
    logic                    arr_write_q;
    logic [PTR_W-1:0]        row_ptr_q;
    logic [N*DATA_WIDTH-1:0] a_q;
    logic [N*DATA_WIDTH-1:0] b_q;
    logic                    enable_q;
    logic [PTR_W-1:0]        beat_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    out_valid_q;
    logic [PTR_W-1:0]        out_row_q;
    logic                    out_last_q;

    logic             load_hs;
    logic             drain_hs;
    logic             cap_we;
    logic [PTR_W-1:0] cap_addr;

    assign load_hs  = (state_q == S_LOAD) && in_ready_q && in_valid;
    assign drain_hs = (state_q == S_DRAIN) && out_valid_q && out_ready;
    assign cap_we   = (state_q == S_COMPUTE) && (cnt_q >= CNT_W'(COMPUTE_LAT));
    assign cap_addr = PTR_W'(cnt_q - CNT_W'(COMPUTE_LAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clear_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            arr_write_q <= 1'b0;
            row_ptr_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            enable_q    <= 1'b0;
            beat_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            clear_q     <= 1'b0;
            arr_write_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q <= S_CLEAR;
                        clear_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q    <= S_LOAD;
                    in_ready_q <= 1'b1;
                    beat_q     <= '0;
                end
                S_LOAD: begin
                    if (load_hs) begin
                        a_q         <= in_a;
                        b_q         <= in_b;
                        arr_write_q <= 1'b1;
                        row_ptr_q   <= beat_q;
                        beat_q      <= beat_q + PTR_W'(1);
                        if (beat_q == PTR_W'(N - 1)) begin
                            in_ready_q <= 1'b0;
                        end
                    end
                    // in_ready low inside LOAD means the final write is on the array bus now.
                    if (!in_ready_q) begin
                        state_q  <= S_COMPUTE;
                        enable_q <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                S_COMPUTE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(COMPUTE_LAT + N - 1)) begin
                        enable_q    <= 1'b0;
                        state_q     <= S_DRAIN;
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                        out_last_q  <= (N == 1);
                    end
                end
                S_DRAIN: begin
                    if (drain_hs) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_row_q   <= '0;
                            state_q     <= S_IDLE;
                        end else begin
                            out_row_q  <= out_row_q + PTR_W'(1);
                            out_last_q <= (out_row_q == PTR_W'(N - 2));
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    mm8_result_buf #(
        .N         (N),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_buf (
        .clk     (clk),
        .we_i    (cap_we),
        .waddr_i (cap_addr),
        .wdata_i (arr_c_out),
        .raddr_i (out_row_q),
        .rdata_o (out_c)
    );

    // arr_rst follows rst directly so the array clears in the same cycles the controller does.
    assign arr_rst     = rst | clear_q;
    assign in_ready    = in_ready_q;
    assign arr_write   = arr_write_q;
    assign arr_row_ptr = row_ptr_q;
    assign arr_a_in    = a_q;
    assign arr_b_in    = b_q;
    assign arr_enable  = enable_q;
    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign out_last    = out_last_q;
    assign busy        = (state_q != S_IDLE);

`ifdef MM_CTRL_PERF_EN
    logic [31:0] perf_cnt_q;
    logic [31:0] perf_q;
    logic        perf_run_q;

    // Counts inclusively from the first LOAD handshake to the out_last handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
            perf_run_q <= 1'b0;
        end else begin
            if (load_hs && beat_q == '0) begin
                perf_run_q <= 1'b1;
                perf_cnt_q <= 32'd1;
            end else if (perf_run_q) begin
                perf_cnt_q <= perf_cnt_q + 32'd1;
            end
            if (drain_hs && out_last_q && perf_run_q) begin
                perf_q     <= perf_cnt_q + 32'd1;
                perf_run_q <= 1'b0;
            end
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mm8_ctrl.sv
// Self-checking bench for mm8_ctrl with a behavioural array model and matrix-product reference.
module tb_mm8_ctrl;
    import mm8_pkg::*;

    localparam int N   = 8;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int LAT = 17;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_a;
    logic [N*DW-1:0] in_b;
    logic            arr_rst;
    logic            arr_write;
    logic [2:0]      arr_row_ptr;
    logic [N*DW-1:0] arr_a_in;
    logic [N*DW-1:0] arr_b_in;
    logic            arr_enable;
    logic [N*AW-1:0] arr_c_out;
    logic            out_valid;
    logic            out_ready;
    logic [N*AW-1:0] out_c;
    logic [2:0]      out_row;
    logic            out_last;
    logic            busy;
`ifdef MM_CTRL_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    mm8_ctrl dut (
`ifdef MM_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .arr_rst     (arr_rst),
        .arr_write   (arr_write),
        .arr_row_ptr (arr_row_ptr),
        .arr_a_in    (arr_a_in),
        .arr_b_in    (arr_b_in),
        .arr_enable  (arr_enable),
        .arr_c_out   (arr_c_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_c       (out_c),
        .out_row     (out_row),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int A  [N][N];
    int B  [N][N];
    int Am [N][N];
    int Bm [N][N];

    int cyc = 0;
    int rst_pulses, en_cnt, en_first, en_last;
    int en_run = 0;
    bit dirty  = 1'b0;
    int              wr_ptrs  [$];
    int              wr_cyc   [$];
    logic [N*AW-1:0] out_rows [$];
    int              out_idx  [$];
    bit              out_lst  [$];

    task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] rnd_row();
        logic [N*AW-1:0] v;
        for (int j = 0; j < N; j++) v[j*AW +: AW] = $urandom;
        return v;
    endfunction

    // Row r of C = A x B from the stimulus matrices.
    function automatic logic [N*AW-1:0] golden_row(input int r);
        logic [N*AW-1:0] v;
        for (int j = 0; j < N; j++) begin
            int s = 0;
            for (int k = 0; k < N; k++) s += A[r][k] * B[k][j];
            v[j*AW +: AW] = s;
        end
        return v;
    endfunction

    // Row r as the array would produce it from what it was actually written.
    function automatic logic [N*AW-1:0] model_row(input int r);
        logic [N*AW-1:0] v;
        for (int j = 0; j < N; j++) begin
            int s = 0;
            for (int k = 0; k < N; k++) s += Am[r][k] * Bm[k][j];
            v[j*AW +: AW] = dirty ? (s ^ 32'hDEAD_0000) : s;
        end
        return v;
    endfunction

    // Array model, bus side: observes writes/clears and logs handshakes.
    always @(posedge clk) begin
        cyc++;
        if (arr_rst) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < N; k++) begin
                    Am[i][k] = 0;
                    Bm[i][k] = 0;
                end
            dirty = 1'b0;
            rst_pulses++;
        end else if (arr_write) begin
            wr_ptrs.push_back(int'(arr_row_ptr));
            wr_cyc.push_back(cyc);
            for (int j = 0; j < N; j++) begin
                Am[j][arr_row_ptr] = $signed(arr_a_in[j*DW +: DW]);
                Bm[j][arr_row_ptr] = $signed(arr_b_in[j*DW +: DW]);
            end
        end
        if (arr_enable) begin
            en_cnt++;
            if (en_first < 0) en_first = cyc;
            en_last = cyc;
        end
        if (out_valid && out_ready) begin
            out_rows.push_back(out_c);
            out_idx.push_back(int'(out_row));
            out_lst.push_back(out_last);
        end
    end

    // Array model, result side: row r appears LAT+r cycles after enable rises.
    always @(negedge clk) begin
        if (arr_enable) begin
            if (en_run >= LAT && en_run < LAT + N) arr_c_out = model_row(en_run - LAT);
            else arr_c_out = rnd_row();
            en_run++;
            if (en_run == LAT + N) dirty = 1'b1;
        end else begin
            en_run    = 0;
            arr_c_out = rnd_row();
        end
    end

    task automatic set_mats(input bit ident);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (ident) begin
                    A[i][j] = (i == j) ? 1 : 0;
                    B[i][j] = i * 8 + j;
                end else begin
                    A[i][j] = int'($urandom_range(0, 255)) - 128;
                    B[i][j] = int'($urandom_range(0, 255)) - 128;
                end
            end
    endtask

    task automatic load_phase(input bit bubbles, input string tag);
        int k     = 0;
        int guard = 0;
        bit tog   = 1'b1;
        wr_ptrs.delete(); wr_cyc.delete();
        out_rows.delete(); out_idx.delete(); out_lst.delete();
        rst_pulses = 0; en_cnt = 0; en_first = -1; en_last = -1;
        while (k < N && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid = !bubbles || tog;
            tog      = !tog;
            for (int j = 0; j < N; j++) begin
                in_a[j*DW +: DW] = A[j][k][DW-1:0];
                in_b[j*DW +: DW] = B[j][k][DW-1:0];
            end
            if (in_valid && in_ready) k++;
        end
        check({tag, "_beats_accepted"}, k, N);
    endtask

    task automatic drain_phase(input int stall_row, input int stall_len, input string tag);
        int guard = 0;
        bit stalled = 1'b0;
        logic [N*AW-1:0] held;
        while (out_rows.size() < N && guard < 300) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b0;
            if (stall_row >= 0 && !stalled && out_valid && out_row == 3'(stall_row)) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                held      = out_c;
                repeat (stall_len) begin
                    @(negedge clk);
                    check({tag, "_stall_hold"}, {out_valid, out_row, out_c},
                          {1'b1, 3'(stall_row), held});
                end
                out_ready = 1'b1;
            end
        end
        repeat (4) @(negedge clk);
        check({tag, "_row_count"}, out_rows.size(), N);
        check({tag, "_idle_after"}, {out_valid, busy}, 2'b00);
    endtask

    task automatic verify(input bit bubbles, input string tag);
        logic [23:0] got_ptr = '0;
        logic [23:0] exp_ptr = '0;
        check({tag, "_clear_pulse"}, rst_pulses, 1);
        check({tag, "_write_count"}, wr_ptrs.size(), N);
        for (int i = 0; i < N && i < wr_ptrs.size(); i++) begin
            got_ptr[i*3 +: 3] = 3'(wr_ptrs[i]);
            exp_ptr[i*3 +: 3] = 3'(i);
        end
        check({tag, "_row_ptr_seq"}, got_ptr, exp_ptr);
        if (wr_cyc.size() == N)
            check({tag, "_write_span"}, wr_cyc[N-1] - wr_cyc[0], bubbles ? 14 : 7);
        check({tag, "_enable_cycles"}, en_cnt, LAT + N);
        check({tag, "_enable_contig"}, en_last - en_first + 1, LAT + N);
        for (int r = 0; r < out_rows.size(); r++) begin
            check($sformatf("%s_row%0d_data", tag, r), out_rows[r], golden_row(r));
            check($sformatf("%s_row%0d_index", tag, r), out_idx[r], r);
            check($sformatf("%s_row%0d_last", tag, r), out_lst[r], (r == N - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_arr_rst", arr_rst, 1'b1);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_array_bus", {arr_write, arr_enable, arr_row_ptr, arr_a_in, arr_b_in}, '0);
        check("rst_out_ctrl", {out_row, out_last}, '0);
`ifdef MM_CTRL_PERF_EN
        check("rst_perf", perf_cycles, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_arr_rst", arr_rst, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        // Job 1: identity x ramp, contiguous stream, no backpressure.
        set_mats(1'b1);
        load_phase(1'b0, "j1");
        drain_phase(-1, 0, "j1");
        verify(1'b0, "j1");
`ifdef MM_CTRL_PERF_EN
        check("j1_perf", perf_cycles, 8 + 1 + LAT + 8 + 8);
`endif

        // Job 2: same operands with input bubbles.
        repeat (3) @(negedge clk);
        load_phase(1'b1, "j2");
`ifdef MM_CTRL_PERF_EN
        check("j2_perf_held", perf_cycles, 8 + 1 + LAT + 8 + 8);
`endif
        drain_phase(-1, 0, "j2");
        verify(1'b1, "j2");
`ifdef MM_CTRL_PERF_EN
        check("j2_perf", perf_cycles, 15 + 1 + LAT + 8 + 8);
`endif

        // Job 3: random operands, issued straight after the previous drain, stalled at row 3.
        set_mats(1'b0);
        load_phase(1'b0, "j3");
        drain_phase(3, 10, "j3");
        verify(1'b0, "j3");

        // Reset during compute at counter 5, then a fresh job.
        set_mats(1'b0);
        load_phase(1'b0, "j4");
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (!arr_enable && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("mid_enable_seen", arr_enable, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_enable", arr_enable, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_outs", {out_valid, in_ready, arr_write, arr_rst}, 4'b0001);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_quiet", {out_valid, busy, arr_enable}, 3'b000);

        set_mats(1'b0);
        load_phase(1'b0, "j5");
        drain_phase(-1, 0, "j5");
        verify(1'b0, "j5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
